text_box_motion_ctrl: RTL and testbench
=======================================

Name: text_box_motion_ctrl

Overview:
Controller that sequences the text-overlay datapath. It holds the displayed character string and the text-box origin, and drives the i_characters, i_x, i_y and i_rd_en inputs of the overlay renderer. New messages are loaded over a valid/ready byte stream into a shadow buffer, and the shadow is committed only at a frame boundary so text never tears. While enabled, the box is moved by a fixed step every N frames and bounces off the edges of the active area.

Parameters:
HORIZONTAL_WIDTH, 1650, total horizontal pixel count; sets the o_x width to $clog2(HORIZONTAL_WIDTH)
VERTICAL_WIDTH, 750, total vertical line count; sets the o_y width to $clog2(VERTICAL_WIDTH)
ACTIVE_W, 1280, active pixels per line
ACTIVE_H, 720, active lines
COLUMNS, 13, number of characters in the box
GLYPH_W, 8, glyph width in pixels
GLYPH_H, 16, glyph height in pixels
STEP_X, 2, horizontal pixels moved per step
STEP_Y, 1, vertical lines moved per step
FRAMES_PER_STEP, 1, frames between position steps (must be ≥1)

Ports:
i_clk  in  1  pixel clock; the only clock
i_rst  in  1  synchronous reset, active-high
i_nf  in  1  one-cycle pulse at the start of each frame
i_run  in  1  motion enable
i_wr_valid  in  1  character byte valid
i_wr_data  in  8  character code
i_wr_last  in  1  marks the final byte of a message
o_wr_ready  out  1  controller accepts a byte
o_x  out  $clog2(HORIZONTAL_WIDTH)  box origin x
o_y  out  $clog2(VERTICAL_WIDTH)  box origin y
o_characters  out  COLUMNS*8  displayed string; char 0 sits at [COLUMNS*8-1 -: 8], string-literal packing
o_box_en  out  1  renderer read enable
o_busy  out  1  high in LOAD or COMMIT

Behaviour:
- Reset values: o_x=0, o_y=0, direction right and down, o_characters = all 8'h20, shadow = all 8'h20, o_box_en=0, o_wr_ready=1, o_busy=0, frame counter=0, write index=0, state IDLE. All outputs are registered.
- Derived limits: MAX_X = ACTIVE_W - COLUMNS*GLYPH_W (default 1176); MAX_Y = ACTIVE_H - GLYPH_H (default 704). Elaboration error if MAX_X < STEP_X or MAX_Y < STEP_Y.
- A byte is accepted only when i_wr_valid && o_wr_ready. Bytes presented while o_wr_ready=0 are ignored (not queued).
- IDLE: o_wr_ready=1. An accepted byte is written to shadow[0] and the index becomes 1. If i_wr_last is set on that beat, go to COMMIT; otherwise go to LOAD.
- LOAD: o_wr_ready=1. Each accepted byte is written to shadow[index] and the index increments. The message completes when i_wr_last is accepted or when byte COLUMNS-1 is accepted, whichever comes first. On completion, the slots after the last written byte are filled with 8'h20 and the state goes to COMMIT. Bytes beyond COLUMNS cannot occur, because ready drops at completion.
- COMMIT: o_wr_ready=0. On i_nf, o_characters <= shadow, o_box_en <= 1, index clears, and the state goes to SHOW.
- SHOW: o_wr_ready=1. An accepted byte starts a new load (to LOAD, as from IDLE). o_characters and o_box_en hold their old values until the next commit.
- Commit timing: an i_nf in the same cycle as the completing write does not commit; commit happens on the following i_nf.
- Motion runs in any state while o_box_en=1 && i_run. On each i_nf the frame counter increments; when it equals FRAMES_PER_STEP-1 it clears and a step executes. o_x and o_y are valid the cycle after i_nf.
- Step in x, moving right: if x + STEP_X ≥ MAX_X, then x = MAX_X and direction becomes left; otherwise x += STEP_X.
- Step in x, moving left: if x ≤ STEP_X, then x = 0 and direction becomes right; otherwise x -= STEP_X.
- Step in y: same rules using STEP_Y and MAX_Y.
- Arithmetic is one bit wider than the output so overflow cannot wrap.
- i_run=0 freezes the position and holds the frame counter.
- i_rst at any time, including mid-load, restores all reset values on the next edge and discards the shadow.

Test Plan:
1. Reset, then stream "Hello, world!" (13 bytes, last on byte 13) → o_wr_ready=0 and o_busy=1 after byte 13; o_characters stays all 8'h20 until the next i_nf; the cycle after it, o_characters = "Hello, world!", o_box_en=1, o_wr_ready=1.
2. Stream "Hi" with i_wr_last on 'i' → after commit, o_characters = "Hi" followed by 11×8'h20.
3. Defaults, i_run=1, box shown at (0,0) → after one i_nf, (2,1); after 588 steps o_x=1176, and the next step gives o_x=1174 (bounce). The same check for y at 704.
4. FRAMES_PER_STEP=3 → o_x advances only on every 3rd i_nf (0,0,2,2,2,4); toggling i_run=0 holds both the position and the counter.
5. While showing, load "Bye" with i_nf pulsing during the load → old text and o_box_en=1 persist; the swap occurs on the first i_nf after completion, not one coincident with the last byte.
6. Assert i_rst after 5 bytes of a load → next cycle: state IDLE, o_wr_ready=1, o_characters all 8'h20, o_box_en=0, (0,0); a following full load works normally.

Source files
------------

// File: rtl/text_box_motion_ctrl.sv
// rtl/text_box_motion_ctrl.sv - text overlay controller: tear-free message load and bouncing box origin
// Bytes fill a shadow string that is swapped onto the display only at a frame start.
module text_box_motion_ctrl #(
  parameter int HORIZONTAL_WIDTH = 1650,
  parameter int VERTICAL_WIDTH   = 750,
  parameter int ACTIVE_W         = 1280,
  parameter int ACTIVE_H         = 720,
  parameter int COLUMNS          = 13,
  parameter int GLYPH_W          = 8,
  parameter int GLYPH_H          = 16,
  parameter int STEP_X           = 2,
  parameter int STEP_Y           = 1,
  parameter int FRAMES_PER_STEP  = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_nf,
  input  logic                                i_run,
  input  logic                                i_wr_valid,
  input  logic [7:0]                          i_wr_data,
  input  logic                                i_wr_last,
  output logic                                o_wr_ready,
  output logic [$clog2(HORIZONTAL_WIDTH)-1:0] o_x,
  output logic [$clog2(VERTICAL_WIDTH)-1:0]   o_y,
  output logic [COLUMNS*8-1:0]                o_characters,
  output logic                                o_box_en,
  output logic                                o_busy
);

  localparam int XW    = $clog2(HORIZONTAL_WIDTH);
  localparam int YW    = $clog2(VERTICAL_WIDTH);
  localparam int MAX_X = ACTIVE_W - COLUMNS * GLYPH_W;
  localparam int MAX_Y = ACTIVE_H - GLYPH_H;
  localparam int IW    = $clog2(COLUMNS + 1);
  localparam int FCW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [XW:0]            MAX_XV  = (XW+1)'(MAX_X);
  localparam logic [XW:0]            STEP_XV = (XW+1)'(STEP_X);
  localparam logic [YW:0]            MAX_YV  = (YW+1)'(MAX_Y);
  localparam logic [YW:0]            STEP_YV = (YW+1)'(STEP_Y);
  localparam logic [XW-1:0]          MAX_XO  = XW'(MAX_X);
  localparam logic [YW-1:0]          MAX_YO  = YW'(MAX_Y);
  localparam logic [IW-1:0]          LAST_IX = IW'(COLUMNS - 1);
  localparam logic [FCW-1:0]         FC_TOP  = FCW'(FRAMES_PER_STEP - 1);
  localparam logic [COLUMNS*8-1:0]   BLANK   = {COLUMNS{8'h20}};

  if (MAX_X < STEP_X || MAX_Y < STEP_Y) begin : g_bad_limits
    $error("text box does not fit the active area for the chosen step");
  end
  if (FRAMES_PER_STEP < 1) begin : g_bad_fps
    $error("FRAMES_PER_STEP must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_SHOW} state_t;

  state_t               state_q, state_d;
  logic [COLUMNS*8-1:0] shadow_q, shadow_d;
  logic [COLUMNS*8-1:0] chars_q, chars_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 box_en_q, box_en_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 busy_q, busy_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 right_q, right_d;
  logic                 down_q, down_d;
  logic [FCW-1:0]       fcnt_q, fcnt_d;
  logic                 accept;
  logic [XW:0]          x_wide, x_fwd;
  logic [YW:0]          y_wide, y_fwd;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    chars_d  = chars_q;
    idx_d    = idx_q;
    box_en_d = box_en_q;
    accept   = i_wr_valid && wr_ready_q;
    case (state_q)
      S_IDLE, S_SHOW: begin
        // Pre-blanking the shadow makes short messages space-padded for free.
        if (accept) begin
          shadow_d = BLANK;
          shadow_d[COLUMNS*8-1 -: 8] = i_wr_data;
          idx_d    = IW'(1);
          state_d  = (i_wr_last || COLUMNS == 1) ? S_COMMIT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          shadow_d[COLUMNS*8-1 - 8*int'(idx_q) -: 8] = i_wr_data;
          idx_d = idx_q + 1'b1;
          if (i_wr_last || idx_q == LAST_IX) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (i_nf) begin
          chars_d  = shadow_q;
          box_en_d = 1'b1;
          idx_d    = '0;
          state_d  = S_SHOW;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_ready_d = (state_d != S_COMMIT);
    busy_d     = (state_d == S_LOAD) || (state_d == S_COMMIT);
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    right_d = right_q;
    down_d  = down_q;
    fcnt_d  = fcnt_q;
    x_wide  = {1'b0, x_q};
    y_wide  = {1'b0, y_q};
    x_fwd   = x_wide + STEP_XV;
    y_fwd   = y_wide + STEP_YV;
    if (box_en_q && i_run && i_nf) begin
      if (fcnt_q == FC_TOP) begin
        fcnt_d = '0;
        if (right_q) begin
          if (x_fwd >= MAX_XV) begin
            x_d     = MAX_XO;
            right_d = 1'b0;
          end else x_d = x_fwd[XW-1:0];
        end else begin
          if (x_wide <= STEP_XV) begin
            x_d     = '0;
            right_d = 1'b1;
          end else x_d = x_q - STEP_XV[XW-1:0];
        end
        if (down_q) begin
          if (y_fwd >= MAX_YV) begin
            y_d    = MAX_YO;
            down_d = 1'b0;
          end else y_d = y_fwd[YW-1:0];
        end else begin
          if (y_wide <= STEP_YV) begin
            y_d    = '0;
            down_d = 1'b1;
          end else y_d = y_q - STEP_YV[YW-1:0];
        end
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      shadow_q   <= BLANK;
      chars_q    <= BLANK;
      idx_q      <= '0;
      box_en_q   <= 1'b0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      right_q    <= 1'b1;
      down_q     <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      chars_q    <= chars_d;
      idx_q      <= idx_d;
      box_en_q   <= box_en_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      right_q    <= right_d;
      down_q     <= down_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign o_wr_ready   = wr_ready_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_characters = chars_q;
  assign o_box_en     = box_en_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_text_box_motion_ctrl.sv
// tb/tb_text_box_motion_ctrl.sv - bench for text_box_motion_ctrl
// Drives one stream into two instances (1 and 3 frames per step) against a transaction-level model.
module tb_text_box_motion_ctrl;
  localparam int COLS = 13;
  localparam int MAXX = 1176;
  localparam int MAXY = 704;

  logic clk = 1'b0;
  logic rst, nf, run, wv, wl;
  logic [7:0] wd;

  logic rdy_a, be_a, busy_a, rdy_b, be_b, busy_b;
  logic [10:0] x_a, x_b;
  logic [9:0] y_a, y_b;
  logic [COLS*8-1:0] ch_a, ch_b;

  always #5 clk = ~clk;

  text_box_motion_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_nf(nf), .i_run(run), .i_wr_valid(wv), .i_wr_data(wd),
    .i_wr_last(wl), .o_wr_ready(rdy_a), .o_x(x_a), .o_y(y_a), .o_characters(ch_a),
    .o_box_en(be_a), .o_busy(busy_a)
  );

  text_box_motion_ctrl #(.FRAMES_PER_STEP(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_nf(nf), .i_run(run), .i_wr_valid(wv), .i_wr_data(wd),
    .i_wr_last(wl), .o_wr_ready(rdy_b), .o_x(x_b), .o_y(y_b), .o_characters(ch_b),
    .o_box_en(be_b), .o_busy(busy_b)
  );

  int checks = 0;
  int passes = 0;

  byte shown_m[COLS];
  byte shadow_m[COLS];
  int  idx_m;
  bit  loading_m, pending_m, box_en_m;
  int  px[2], py[2], cnt[2];
  bit  rgt[2], dwn[2];
  int  fps[2] = '{1, 3};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic axis(inout int p, inout bit fwd, input int st, input int lim);
    if (fwd) begin
      if (p + st >= lim) begin p = lim; fwd = 0; end
      else p = p + st;
    end else begin
      if (p <= st) begin p = 0; fwd = 1; end
      else p = p - st;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < COLS; i++) begin shown_m[i] = 8'h20; shadow_m[i] = 8'h20; end
    idx_m = 0; loading_m = 0; pending_m = 0; box_en_m = 0;
    for (int k = 0; k < 2; k++) begin px[k] = 0; py[k] = 0; cnt[k] = 0; rgt[k] = 1; dwn[k] = 1; end
  endtask

  function automatic logic [COLS*8-1:0] shown_packed();
    logic [COLS*8-1:0] v;
    for (int i = 0; i < COLS; i++) v[(COLS-i)*8-1 -: 8] = shown_m[i];
    return v;
  endfunction

  task automatic compare();
    chk("ready_a", rdy_a, !pending_m);
    chk("ready_b", rdy_b, !pending_m);
    chk("busy_a", busy_a, loading_m || pending_m);
    chk("busy_b", busy_b, loading_m || pending_m);
    chk("box_en_a", be_a, box_en_m);
    chk("box_en_b", be_b, box_en_m);
    chk("chars_a", ch_a, shown_packed());
    chk("chars_b", ch_b, shown_packed());
    chk("x_a", x_a, px[0]);
    chk("y_a", y_a, py[0]);
    chk("x_b", x_b, px[1]);
    chk("y_b", y_b, py[1]);
  endtask

  task automatic cycle(input bit r, input bit n, input bit v, input logic [7:0] d, input bit l);
    bit ready_now;
    int tx, ty;
    bit tr, td;
    rst = r; nf = n; wv = v; wd = d; wl = l;
    if (r) model_reset();
    else begin
      ready_now = !pending_m;
      if (n && box_en_m && run) begin
        for (int k = 0; k < 2; k++) begin
          if (cnt[k] == fps[k] - 1) begin
            cnt[k] = 0;
            tx = px[k]; tr = rgt[k]; ty = py[k]; td = dwn[k];
            axis(tx, tr, 2, MAXX);
            axis(ty, td, 1, MAXY);
            px[k] = tx; rgt[k] = tr; py[k] = ty; dwn[k] = td;
          end else cnt[k]++;
        end
      end
      if (n && pending_m) begin
        shown_m = shadow_m; box_en_m = 1; pending_m = 0;
      end
      if (v && ready_now) begin
        if (!loading_m) begin
          for (int i = 0; i < COLS; i++) shadow_m[i] = 8'h20;
          idx_m = 0; loading_m = 1;
        end
        shadow_m[idx_m] = d;
        idx_m++;
        if (l || idx_m == COLS) begin loading_m = 0; pending_m = 1; end
      end
    end
    @(posedge clk); #1;
    compare();
  endtask

  task automatic send(input string s, input bit with_last, input bit nf_each);
    for (int i = 0; i < s.len(); i++)
      cycle(0, nf_each, 1, s[i], with_last && (i == s.len() - 1));
  endtask

  task automatic idle(input int n_cyc);
    for (int i = 0; i < n_cyc; i++) cycle(0, 0, 0, 8'h00, 0);
  endtask

  logic [COLS*8-1:0] blank_s = {COLS{8'h20}};
  logic [COLS*8-1:0] hello_s = "Hello, world!";
  logic [COLS*8-1:0] hi_s    = {"Hi", {11{8'h20}}};
  logic [COLS*8-1:0] bye_s   = {"Bye", {10{8'h20}}};
  logic [COLS*8-1:0] dig_s   = "0123456789ABC";
  int b_table[6] = '{0, 0, 2, 2, 2, 4};

  initial begin
    rst = 1; nf = 0; run = 0; wv = 0; wd = 8'h00; wl = 0;
    model_reset();
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    chk("reset_ready", rdy_a, 1'b1);
    chk("reset_chars", ch_a, blank_s);
    chk("reset_xy", {x_a, y_a}, 21'd0);
    idle(2);

    send("Hello, world!", 1, 0);
    chk("hello_ready_low", rdy_a, 1'b0);
    chk("hello_busy", busy_a, 1'b1);
    idle(3);
    chk("hello_not_yet", ch_a, blank_s);
    cycle(0, 1, 0, 8'h00, 0);
    chk("hello_commit", ch_a, hello_s);
    chk("hello_box_en", be_a, 1'b1);
    chk("hello_ready_back", rdy_a, 1'b1);

    send("Hi", 1, 0);
    idle(2);
    cycle(0, 1, 0, 8'h00, 0);
    chk("hi_commit", ch_a, hi_s);

    run = 1;
    for (int k = 1; k <= 720; k++) begin
      cycle(0, 1, 0, 8'h00, 0);
      if (k == 1)   chk("step1_xy", {x_a, y_a}, {11'd2, 10'd1});
      if (k <= 6)   chk("fps3_x", x_b, b_table[k-1]);
      if (k == 588) chk("x_hits_max", x_a, 11'd1176);
      if (k == 589) chk("x_bounce", x_a, 11'd1174);
      if (k == 704) chk("y_hits_max", y_a, 10'd704);
      if (k == 705) chk("y_bounce", y_a, 10'd703);
      cycle(0, 0, 0, 8'h00, 0);
    end

    for (int i = 0; i < 200; i++) begin
      run = ($urandom_range(0, 1) == 1);
      cycle(0, $urandom_range(0, 2) == 0, 0, 8'h00, 0);
    end
    run = 1;

    send("Bye", 1, 1);
    chk("bye_old_text", ch_a, hi_s);
    chk("bye_box_en", be_a, 1'b1);
    idle(2);
    cycle(0, 1, 0, 8'h00, 0);
    chk("bye_commit", ch_a, bye_s);

    send("ABCDE", 0, 0);
    cycle(1, 0, 0, 8'h00, 0);
    chk("midload_rst_ready", rdy_a, 1'b1);
    chk("midload_rst_chars", ch_a, blank_s);
    chk("midload_rst_box", be_a, 1'b0);
    chk("midload_rst_xy", {x_a, y_a}, 21'd0);
    send("0123456789ABCDEF", 0, 0);
    cycle(0, 1, 0, 8'h00, 0);
    chk("full_commit", ch_a, dig_s);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) run = ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) != 0, 8'($urandom_range(32, 126)),
            $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
